// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame geometry, FSM states, parity helper.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam logic        UART_IDLE_LVL  = 1'b1;
   localparam logic        UART_START_LVL = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   // Even parity: XOR of all data bits.
   function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter; tick marks the last clock of each serial bit.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;

   // With one clock per bit CNT_MAX is zero, so tick is permanently high.
   assign tick = (cnt_q == CNT_MAX);

   // Count 0..CLKS_PER_BIT-1, wrapping on tick; clear realigns on frame accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, stop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter int unsigned PARITY_EN    = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [UART_DATA_BITS-1:0] data_in,
   input  logic                      tx_valid,
   output logic                      tx_ready,
   output logic                      tx,
   output logic                      tx_busy,
   output logic                      tx_done
);

   localparam int unsigned BIT_CNT_W = $clog2(UART_DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

   uart_state_e               state_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [BIT_CNT_W-1:0]      bit_cnt_q;
   logic                      parity_q;
   logic                      tx_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      accept_c;
   logic                      tick_c;

   assign tx_ready = (state_q == ST_IDLE);
   assign accept_c = tx_ready && tx_valid;
   assign tx       = tx_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

   // Bit-period timing, restarted on every accepted byte.
   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(accept_c),
      .tick (tick_c)
   );

   // Frame FSM; tx is loaded with the level of the state being entered so the
   // line changes on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= UART_IDLE_LVL;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q   <= UART_IDLE_LVL;
               busy_q <= 1'b0;
               if (tx_valid) begin
                  shift_q   <= data_in;
                  parity_q  <= uart_parity(data_in);
                  bit_cnt_q <= '0;
                  tx_q      <= UART_START_LVL;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               if (tick_c) begin
                  tx_q    <= shift_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick_c) begin
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        tx_q    <= parity_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= UART_IDLE_LVL;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     tx_q <= shift_q[1];
                  end
               end
            end
            ST_PARITY: begin
               if (tick_c) begin
                  tx_q    <= UART_IDLE_LVL;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick_c) begin
                  tx_q    <= UART_IDLE_LVL;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               tx_q    <= UART_IDLE_LVL;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (1 clk/bit, 4 clk/bit, no parity).
module tb_uart_tx;

   logic clk;
   logic rst;

   logic [7:0] a_data, b_data, c_data;
   logic       a_valid, b_valid, c_valid;
   logic       a_ready, b_ready, c_ready;
   logic       a_tx, b_tx, c_tx;
   logic       a_busy, b_busy, c_busy;
   logic       a_done, b_done, c_done;

   int checks   = 0;
   int failures = 0;

   // Hand-computed line sequences (start, data LSB first, parity, stop).
   logic exp_a5 [11] = '{0, 1,0,1,0,0,1,0,1, 0, 1};
   logic exp_07 [11] = '{0, 1,1,1,0,0,0,0,0, 1, 1};
   logic exp_b2b[23] = '{0, 0,0,0,0,0,0,0,0, 0, 1,
                         1,
                         0, 1,1,1,1,1,1,1,1, 0, 1};
   logic exp_3c [10] = '{0, 0,0,1,1,1,1,0,0, 1};

   uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut_a (
      .clk(clk), .rst(rst), .data_in(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done));

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_b (
      .clk(clk), .rst(rst), .data_in(b_data), .tx_valid(b_valid),
      .tx_ready(b_ready), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done));

   uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
      .clk(clk), .rst(rst), .data_in(c_data), .tx_valid(c_valid),
      .tx_ready(c_ready), .tx(c_tx), .tx_busy(c_busy), .tx_done(c_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Send 8'hA5 on instance A and check every cycle of the frame and tx_done.
   task automatic send_a5_checked();
      a_data  = 8'hA5;
      a_valid = 1'b1;
      chk("a5_ready_before", a_ready, 1'b1);
      step();
      a_valid = 1'b0;
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("a5_tx[%0d]", i), a_tx, exp_a5[i]);
         chk($sformatf("a5_busy[%0d]", i), a_busy, 1'b1);
         chk($sformatf("a5_ready[%0d]", i), a_ready, 1'b0);
         chk($sformatf("a5_done[%0d]", i), a_done, 1'b0);
         step();
      end
      chk("a5_done_pulse", a_done, 1'b1);
      chk("a5_ready_after", a_ready, 1'b1);
      chk("a5_busy_after", a_busy, 1'b0);
      chk("a5_tx_after", a_tx, 1'b1);
      step();
      chk("a5_done_cleared", a_done, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
      #2;
      chk("rst_tx", a_tx, 1'b1);
      chk("rst_ready", a_ready, 1'b1);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Idle line after reset
      for (int i = 0; i < 20; i++) begin
         chk("idle_tx", a_tx, 1'b1);
         chk("idle_ready", a_ready, 1'b1);
         chk("idle_busy", a_busy, 1'b0);
         chk("idle_done", a_done, 1'b0);
         step();
      end

      // 8'hA5, one clock per bit
      send_a5_checked();

      // 8'h07, four clocks per bit
      b_data  = 8'h07;
      b_valid = 1'b1;
      step();
      b_valid = 1'b0;
      for (int i = 0; i < 44; i++) begin
         chk($sformatf("b07_tx[%0d]", i), b_tx, exp_07[i / 4]);
         chk($sformatf("b07_busy[%0d]", i), b_busy, 1'b1);
         chk($sformatf("b07_done[%0d]", i), b_done, 1'b0);
         step();
      end
      chk("b07_done_pulse", b_done, 1'b1);
      chk("b07_busy_after", b_busy, 1'b0);
      chk("b07_ready_after", b_ready, 1'b1);
      step();

      // Back-to-back with tx_valid held; data_in changes after first accept
      a_data  = 8'h00;
      a_valid = 1'b1;
      step();
      a_data  = 8'hFF;
      for (int i = 0; i < 23; i++) begin
         if (i == 12) a_valid = 1'b0;
         chk($sformatf("b2b_tx[%0d]", i), a_tx, exp_b2b[i]);
         chk($sformatf("b2b_done[%0d]", i), a_done, (i == 11) ? 1'b1 : 1'b0);
         chk($sformatf("b2b_busy[%0d]", i), a_busy, (i == 11) ? 1'b0 : 1'b1);
         step();
      end
      chk("b2b_done_pulse2", a_done, 1'b1);
      chk("b2b_ready_after", a_ready, 1'b1);
      step();

      // Reset in the middle of a frame
      a_data  = 8'hA5;
      a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      repeat (4) step();
      chk("mid_tx_before_rst", a_tx, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", a_tx, 1'b1);
      chk("mid_rst_ready", a_ready, 1'b1);
      chk("mid_rst_busy", a_busy, 1'b0);
      chk("mid_rst_done", a_done, 1'b0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("post_rst_done", a_done, 1'b0);
         chk("post_rst_tx", a_tx, 1'b1);
         step();
      end
      send_a5_checked();

      // No parity: 8'h3C gives a 10-bit frame
      c_data  = 8'h3C;
      c_valid = 1'b1;
      step();
      c_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("np_tx[%0d]", i), c_tx, exp_3c[i]);
         chk($sformatf("np_busy[%0d]", i), c_busy, 1'b1);
         chk($sformatf("np_done[%0d]", i), c_done, 1'b0);
         step();
      end
      chk("np_done_pulse", c_done, 1'b1);
      chk("np_ready_after", c_ready, 1'b1);
      chk("np_tx_after", c_tx, 1'b1);
      step();
      chk("np_done_cleared", c_done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
